mips_multicycle_controller: RTL
===============================

Name: mips_multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback over the shared ALU, register file and unified memory.
- Drives the extender mode: sign-extend by default, zero-extend for andi/ori.
- Waits on a memory ready handshake so the image memory can insert wait states.

Parameters:
- OP_W, 6, opcode field width (instr[31:26]).
- FUNCT_W, 6, function field width (instr[5:0]).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  OP_W  opcode from the instruction register.
- funct  in  FUNCT_W  function field from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC load enable; equals pc_write OR (branch AND zero).
- ir_write  out  1  instruction register load.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read request.
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- reg_write  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = extended immediate, 11 = extended immediate << 2.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- ext_zero  out  1  0 = sign-extend imm16, 1 = zero-extend.
- illegal_op  out  1  one-cycle pulse on an unsupported op/funct.
- state_dbg  out  4  current state encoding.

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BEQEX 8, IEX 9, IWB 10, JEX 11.
- Outputs are decoded from state, op and funct; they are not registered.
- Reset asserted: state goes to FETCH immediately. All strobes are 0 while reset is high: pc_en, ir_write, mem_write, mem_read, reg_write, illegal_op.
- Mux outputs hold their FETCH values during reset and in any state that does not set them: alu_src_b = 01, alu_ctrl = 010, all others 0.
- Reset mid-instruction aborts it with no register or memory write.
- FETCH:
  - mem_read = 1 and iord = 0 every cycle.
  - ir_write and pc_write = 1 only in the cycle mem_ready = 1; that cycle also goes to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_b = 11, alu_ctrl = 010 (branch target precompute). Next state by op:
  - 100011 (lw) / 101011 (sw) → MEMADR.
  - 000000 → REX if funct is supported, else illegal_op pulse and → FETCH.
  - 000100 (beq) → BEQEX.
  - 001000 / 001100 / 001101 / 001010 (addi / andi / ori / slti) → IEX.
  - 000010 (j) → JEX.
  - Any other op → illegal_op pulse and → FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. Then lw → MEMRD, sw → MEMWR.
- MEMRD: iord = 1, mem_read = 1. Stay until mem_ready = 1, then → MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Then → FETCH.
- MEMWR: iord = 1, mem_write held at 1. Stay until mem_ready = 1, then → FETCH. mem_write drops on the exit edge.
- REX: alu_src_a = 1, alu_src_b = 00, alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Then → RWB.
- RWB: reg_write = 1, reg_dst = 1. Then → FETCH.
- BEQEX: alu_src_a = 1, alu_src_b = 00, sub, branch = 1, pc_src = 01. pc_en = zero. Then → FETCH.
- IEX: alu_src_a = 1, alu_src_b = 10. Then → IWB.
  - addi: add, ext_zero = 0.
  - andi: and, ext_zero = 1.
  - ori: or, ext_zero = 1.
  - slti: slt, ext_zero = 0.
- IWB: reg_write = 1, reg_dst = 0, ext_zero kept as in IEX. Then → FETCH.
- JEX: pc_write = 1, pc_src = 10. Then → FETCH.
- Cycle counts with zero wait states, FETCH included: lw 5, sw 4, R-type 4, addi-class 4, beq 3, j 3. Each mem_ready = 0 cycle adds one.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Reset pulse mid-MEMWR, then release → state_dbg = 0, mem_write = 0 immediately on assertion; FETCH resumes after release.
- lw (op 100011), mem_ready held 1 → states 0,1,2,3,4. reg_write = 1 only in state 4, with mem_to_reg = 1; 5 cycles total.
- sw, mem_ready low for 3 cycles in MEMWR → mem_write high for exactly 4 cycles, then state 0.
- beq with zero = 1, then with zero = 0 → pc_en = 1 in BEQEX only for the zero = 1 case.
- andi then addi → in IEX, ext_zero = 1 with alu_ctrl = 000, then ext_zero = 0 with alu_ctrl = 010. alu_src_b = 10 in both.
- op 111111, then R-type funct 000000 → illegal_op pulses one cycle in DECODE; next state 0; no reg_write or mem_write.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_controller
// Purpose  : Main control FSM for a multicycle MIPS datapath. Sequences
//            fetch / decode / execute / memory / writeback over a shared ALU,
//            register file and unified memory, and stalls on mem_ready so the
//            memory can insert wait states.
// Ports    : clk, reset (async, active-high)
//            op, funct        - fields from the instruction register
//            zero             - ALU zero flag (beq resolution)
//            mem_ready        - memory finishes the current access this cycle
//            pc_en, ir_write, mem_write, mem_read, reg_write, illegal_op
//                             - strobes (all forced low while reset is high)
//            iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
//            alu_ctrl, ext_zero - datapath mux / ALU controls
//            state_dbg        - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_controller #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ir_write,
    output logic               mem_write,
    output logic               mem_read,
    output logic               iord,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_ctrl,
    output logic               ext_zero,
    output logic               illegal_op,
    output logic [3:0]         state_dbg
);

    localparam logic [3:0] c_S_FETCH  = 4'd0;
    localparam logic [3:0] c_S_DECODE = 4'd1;
    localparam logic [3:0] c_S_MEMADR = 4'd2;
    localparam logic [3:0] c_S_MEMRD  = 4'd3;
    localparam logic [3:0] c_S_MEMWB  = 4'd4;
    localparam logic [3:0] c_S_MEMWR  = 4'd5;
    localparam logic [3:0] c_S_REX    = 4'd6;
    localparam logic [3:0] c_S_RWB    = 4'd7;
    localparam logic [3:0] c_S_BEQEX  = 4'd8;
    localparam logic [3:0] c_S_IEX    = 4'd9;
    localparam logic [3:0] c_S_IWB    = 4'd10;
    localparam logic [3:0] c_S_JEX    = 4'd11;

    localparam logic [OP_W-1:0] c_OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] c_OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] c_OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] c_OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] c_OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] c_OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] c_OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] c_OP_SW    = OP_W'(6'b101011);

    localparam logic [FUNCT_W-1:0] c_FN_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] c_FN_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] c_FN_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] c_FN_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] c_FN_SLT = FUNCT_W'(6'b101010);

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next;

    // Instruction decode helpers shared by next-state and output logic
    logic       w_funct_ok;
    logic [2:0] w_funct_ctrl;
    logic       w_imm_op;
    logic [2:0] w_imm_ctrl;
    logic       w_imm_zext;
    logic       w_decode_illegal;

    always_comb begin
        w_funct_ok   = 1'b1;
        w_funct_ctrl = c_ALU_ADD;
        case (funct)
            c_FN_ADD: w_funct_ctrl = c_ALU_ADD;
            c_FN_SUB: w_funct_ctrl = c_ALU_SUB;
            c_FN_AND: w_funct_ctrl = c_ALU_AND;
            c_FN_OR:  w_funct_ctrl = c_ALU_OR;
            c_FN_SLT: w_funct_ctrl = c_ALU_SLT;
            default:  w_funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        w_imm_op   = 1'b1;
        w_imm_ctrl = c_ALU_ADD;
        w_imm_zext = 1'b0;
        case (op)
            c_OP_ADDI: w_imm_ctrl = c_ALU_ADD;
            c_OP_ANDI: begin w_imm_ctrl = c_ALU_AND; w_imm_zext = 1'b1; end
            c_OP_ORI:  begin w_imm_ctrl = c_ALU_OR;  w_imm_zext = 1'b1; end
            c_OP_SLTI: w_imm_ctrl = c_ALU_SLT;
            default:   w_imm_op   = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J: w_decode_illegal = 1'b0;
            c_OP_RTYPE:                         w_decode_illegal = ~w_funct_ok;
            default:                            w_decode_illegal = ~w_imm_op;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = c_S_FETCH;
        case (r_state)
            c_S_FETCH:  w_next = mem_ready ? c_S_DECODE : c_S_FETCH;
            c_S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = c_S_MEMADR;
                    c_OP_RTYPE:       w_next = w_funct_ok ? c_S_REX : c_S_FETCH;
                    c_OP_BEQ:         w_next = c_S_BEQEX;
                    c_OP_J:           w_next = c_S_JEX;
                    default:          w_next = w_imm_op ? c_S_IEX : c_S_FETCH;
                endcase
            end
            c_S_MEMADR: w_next = (op == c_OP_LW) ? c_S_MEMRD : c_S_MEMWR;
            c_S_MEMRD:  w_next = mem_ready ? c_S_MEMWB : c_S_MEMRD;
            c_S_MEMWR:  w_next = mem_ready ? c_S_FETCH : c_S_MEMWR;
            c_S_REX:    w_next = c_S_RWB;
            c_S_IEX:    w_next = c_S_IWB;
            default:    w_next = c_S_FETCH;
        endcase
    end

    // Output decode; strobes are produced raw here and gated by reset below
    logic w_pc_write, w_branch, w_ir_write, w_mem_write, w_mem_read;
    logic w_reg_write, w_illegal;

    always_comb begin
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b01;
        pc_src      = 2'b00;
        alu_ctrl    = c_ALU_ADD;
        ext_zero    = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            c_S_DECODE: begin
                alu_src_b = 2'b11;
                w_illegal = w_decode_illegal;
            end
            c_S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            c_S_MEMRD: begin
                iord       = 1'b1;
                w_mem_read = 1'b1;
            end
            c_S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            c_S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            c_S_REX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_ctrl  = w_funct_ctrl;
            end
            c_S_RWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
            end
            c_S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_ctrl  = c_ALU_SUB;
                w_branch  = 1'b1;
                pc_src    = 2'b01;
            end
            c_S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = w_imm_ctrl;
                ext_zero  = w_imm_zext;
            end
            c_S_IWB: begin
                w_reg_write = 1'b1;
                // Extender mode stays stable so the written result is unchanged
                ext_zero    = w_imm_zext;
            end
            c_S_JEX: begin
                w_pc_write = 1'b1;
                pc_src     = 2'b10;
            end
            default: ;
        endcase
    end

    // The FSM resets asynchronously, but strobes must also be low in the
    // reset cycle itself, so they are gated combinationally by reset.
    assign pc_en      = ~reset & (w_pc_write | (w_branch & zero));
    assign ir_write   = ~reset & w_ir_write;
    assign mem_write  = ~reset & w_mem_write;
    assign mem_read   = ~reset & w_mem_read;
    assign reg_write  = ~reset & w_reg_write;
    assign illegal_op = ~reset & w_illegal;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire
